// File: rtl/helios_link_pkg.sv
// helios_link_pkg: definitions shared by both ends of a neighbor link that
// crosses an FPGA boundary (neighbor_link_tx and the matching receiver).
//   - link_op_e   : message opcode
//   - *_lsb/_bit  : field offsets within {opcode, odd, root, inc_count}
//   - pack_msg    : builds a message; the caller casts it to its own width
package helios_link_pkg;

  typedef enum logic [1:0] {
    OP_UPDATE = 2'b00,
    OP_INIT   = 2'b01
  } link_op_e;

  // Widest message pack_msg can build; callers truncate to their width.
  localparam int PACK_MAX_W = 64;

  function automatic int inc_lsb();
    return 0;
  endfunction

  function automatic int root_lsb(input int cw);
    return cw;
  endfunction

  function automatic int odd_bit(input int aw, input int cw);
    return aw + cw;
  endfunction

  function automatic int op_lsb(input int aw, input int cw);
    return aw + cw + 1;
  endfunction

  function automatic int msg_width(input int aw, input int cw);
    return aw + cw + 3;
  endfunction

  function automatic logic [PACK_MAX_W-1:0] field_mask(input int w);
    return (PACK_MAX_W'(1) << w) - PACK_MAX_W'(1);
  endfunction

  function automatic logic [PACK_MAX_W-1:0] pack_msg(
    input link_op_e              op,
    input logic                  odd,
    input logic [PACK_MAX_W-1:0] root,
    input logic [PACK_MAX_W-1:0] inc,
    input int                    aw,
    input int                    cw
  );
    logic [PACK_MAX_W-1:0] m;
    m = (PACK_MAX_W'(op) << op_lsb(aw, cw))
      | (PACK_MAX_W'(odd) << odd_bit(aw, cw))
      | ((root & field_mask(aw)) << root_lsb(cw))
      | ((inc & field_mask(cw)) << inc_lsb());
    return m;
  endfunction

endpackage

// File: rtl/neighbor_link_tx.sv
// neighbor_link_tx: transmit end of a neighbor link crossing an FPGA boundary.
// Coalesces changes of the local node's root / odd flag / growth pulses into
// pending state and ships compact UPDATE/INIT messages over valid/ready.
// Growth is tracked locally so is_fully_grown needs no round trip.
//
// Ports:
//   clk, reset (async, active low), initialize (new decoding round)
//   a_old_root_in, a_increase, a_is_odd_cluster : local node link inputs
//   is_fully_grown : growth >= LENGTH (combinational from growth register)
//   tx_valid/tx_ready/tx_data : message channel, tx_data = {op, odd, root, inc}
//
// Build option: NEIGHBOR_LINK_TX_PARITY_EN adds an even-parity MSB to tx_data.
module neighbor_link_tx
  import helios_link_pkg::*;
#(
  parameter  int LENGTH        = 2,
  parameter  int ADDRESS_WIDTH = 12,
  localparam int COUNTER_WIDTH = $clog2(LENGTH + 2),
  localparam int MSG_WIDTH     = 3 + ADDRESS_WIDTH + COUNTER_WIDTH,
`ifdef NEIGHBOR_LINK_TX_PARITY_EN
  localparam int DATA_W        = MSG_WIDTH + 1
`else
  localparam int DATA_W        = MSG_WIDTH
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     initialize,
  input  logic [ADDRESS_WIDTH-1:0] a_old_root_in,
  input  logic                     a_increase,
  input  logic                     a_is_odd_cluster,
  output logic                     is_fully_grown,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [DATA_W-1:0]        tx_data
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} tx_state_e;

  localparam logic [COUNTER_WIDTH-1:0] LEN_C = COUNTER_WIDTH'(LENGTH);

  tx_state_e                state_q, state_d;
  logic [COUNTER_WIDTH-1:0] growth_q, growth_d;
  logic [COUNTER_WIDTH-1:0] pend_inc_q, pend_inc_d;
  logic [ADDRESS_WIDTH-1:0] shadow_root_q, shadow_root_d;
  logic                     shadow_odd_q, shadow_odd_d;
  logic                     init_pend_q, init_pend_d;
  logic                     tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]        tx_data_q, tx_data_d;

  logic                     grow;
  logic                     dirty;
  logic [MSG_WIDTH-1:0]     msg;

  always_comb begin
    state_d       = state_q;
    growth_d      = growth_q;
    pend_inc_d    = pend_inc_q;
    shadow_root_d = shadow_root_q;
    shadow_odd_d  = shadow_odd_q;
    init_pend_d   = init_pend_q;
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;

    // Pulses past LENGTH are dropped, so pend_inc can never push the remote
    // side beyond the edge length.
    grow  = a_increase && !initialize && (growth_q < LEN_C);
    // A pulse in this cycle counts as a change so it rides in the next LOAD.
    dirty = (a_old_root_in != shadow_root_q) || (a_is_odd_cluster != shadow_odd_q)
         || (pend_inc_q != '0) || grow;

    if (init_pend_q)
      msg = MSG_WIDTH'(pack_msg(OP_INIT, 1'b0, '0, '0, ADDRESS_WIDTH, COUNTER_WIDTH));
    else
      msg = MSG_WIDTH'(pack_msg(OP_UPDATE, a_is_odd_cluster, PACK_MAX_W'(a_old_root_in),
                                PACK_MAX_W'(pend_inc_q), ADDRESS_WIDTH, COUNTER_WIDTH));

    if (grow) begin
      growth_d   = growth_q + COUNTER_WIDTH'(1);
      pend_inc_d = pend_inc_q + COUNTER_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: if (dirty || init_pend_q) state_d = S_LOAD;
      S_LOAD: begin
`ifdef NEIGHBOR_LINK_TX_PARITY_EN
        tx_data_d = {^msg, msg};
`else
        tx_data_d = msg;
`endif
        tx_valid_d = 1'b1;
        state_d    = S_SEND;
        if (init_pend_q) begin
          // INIT leaves pending increases alone; they follow as an UPDATE.
          init_pend_d   = 1'b0;
          shadow_root_d = '0;
          shadow_odd_d  = 1'b0;
        end else begin
          shadow_root_d = a_old_root_in;
          shadow_odd_d  = a_is_odd_cluster;
          pend_inc_d    = grow ? COUNTER_WIDTH'(1) : '0;
        end
      end
      S_SEND: if (tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new round restarts local bookkeeping but never withdraws an
    // in-flight message; the INIT goes out after it.
    if (initialize) begin
      growth_d      = '0;
      pend_inc_d    = '0;
      shadow_root_d = '0;
      shadow_odd_d  = 1'b0;
      init_pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      growth_q      <= '0;
      pend_inc_q    <= '0;
      shadow_root_q <= '0;
      shadow_odd_q  <= 1'b0;
      init_pend_q   <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      growth_q      <= growth_d;
      pend_inc_q    <= pend_inc_d;
      shadow_root_q <= shadow_root_d;
      shadow_odd_q  <= shadow_odd_d;
      init_pend_q   <= init_pend_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign is_fully_grown = (growth_q >= LEN_C);
  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;

endmodule

// File: tb/tb_neighbor_link_tx.sv
// Directed bench for neighbor_link_tx with LENGTH=2, ADDRESS_WIDTH=12
// (17-bit message {op[1:0], odd, root[11:0], inc[1:0]}, 18 bits with parity).
module tb_neighbor_link_tx;

`ifdef NEIGHBOR_LINK_TX_PARITY_EN
  localparam int DW = 18;
`else
  localparam int DW = 17;
`endif

  logic          clk;
  logic          reset;
  logic          initialize;
  logic [11:0]   a_old_root_in;
  logic          a_increase;
  logic          a_is_odd_cluster;
  logic          is_fully_grown;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;

  int total = 0;
  int bad   = 0;

  neighbor_link_tx #(.LENGTH(2), .ADDRESS_WIDTH(12)) dut (
    .clk             (clk),
    .reset           (reset),
    .initialize      (initialize),
    .a_old_root_in   (a_old_root_in),
    .a_increase      (a_increase),
    .a_is_odd_cluster(a_is_odd_cluster),
    .is_fully_grown  (is_fully_grown),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_data         (tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] root;
    logic        odd;
    int          stall;
    logic [16:0] exp;
    logic        par;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_msg(input string name, input logic [16:0] exp, input logic par);
    chk({name, "_valid"}, 32'(tx_valid), 32'd1);
    chk({name, "_data"}, 32'(tx_data[16:0]), 32'(exp));
`ifdef NEIGHBOR_LINK_TX_PARITY_EN
    chk({name, "_par"}, 32'(tx_data[17]), 32'(par));
`endif
  endtask

  initial begin
    // root, odd, stall cycles, expected {op,odd,root,inc}, expected parity
    vecs[0] = '{12'h05A, 1'b0, 0, 17'h00168, 1'b0};
    vecs[1] = '{12'h05A, 1'b1, 3, 17'h04168, 1'b1};
    vecs[2] = '{12'hFFF, 1'b1, 2, 17'h07FFC, 1'b1};
    vecs[3] = '{12'h000, 1'b0, 0, 17'h00000, 1'b0};
    vecs[4] = '{12'h800, 1'b0, 1, 17'h02000, 1'b1};
    vecs[5] = '{12'h001, 1'b1, 0, 17'h04004, 1'b0};
    vecs[6] = '{12'h003, 1'b1, 0, 17'h0400C, 1'b1};

    reset = 1'b0; initialize = 1'b0; a_old_root_in = '0; a_increase = 1'b0;
    a_is_odd_cluster = 1'b0; tx_ready = 1'b0;
    step(); step();
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_grown", 32'(is_fully_grown), 32'd0);
    reset = 1'b1;

    // Quiet inputs: nothing to send, stray ready ignored.
    tx_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("idle_valid", 32'(tx_valid), 32'd0);
    end
    chk("idle_grown", 32'(is_fully_grown), 32'd0);
    tx_ready = 1'b0;

    // Table: one UPDATE per record, t+2 latency, stable under stall.
    for (int i = 0; i < 7; i++) begin
      a_old_root_in = vecs[i].root;
      a_is_odd_cluster = vecs[i].odd;
      step();
      chk($sformatf("vec%0d_load", i), 32'(tx_valid), 32'd0);
      step();
      chk_msg($sformatf("vec%0d", i), vecs[i].exp, vecs[i].par);
      for (int s = 0; s < vecs[i].stall; s++) begin
        step();
        chk_msg($sformatf("vec%0d_hold", i), vecs[i].exp, vecs[i].par);
      end
      tx_ready = 1'b1;
      step();
      chk($sformatf("vec%0d_hs", i), 32'(tx_valid), 32'd0);
      tx_ready = 1'b0;
    end

    // Growth: three consecutive pulses, LENGTH=2, long stall.
    a_increase = 1'b1;
    step();
    chk("grow1_grown", 32'(is_fully_grown), 32'd0);
    step();
    chk("grow2_grown", 32'(is_fully_grown), 32'd1);
    chk_msg("grow_msg1", 17'h0400D, 1'b0);
    step();
    a_increase = 1'b0;
    for (int s = 0; s < 10; s++) begin
      step();
      chk_msg("grow_hold", 17'h0400D, 1'b0);
    end
    tx_ready = 1'b1;
    step();
    chk("grow_hs1", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    step();
    chk("grow_load2", 32'(tx_valid), 32'd0);
    step();
    chk_msg("grow_msg2", 17'h0400D, 1'b0);
    tx_ready = 1'b1;
    step();
    chk("grow_hs2", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      step();
      chk("grow_no_third", 32'(tx_valid), 32'd0);
    end
    chk("grow_sat", 32'(is_fully_grown), 32'd1);

    // initialize during a stalled SEND, with a same-cycle increase.
    a_old_root_in = 12'h05A;
    step();
    step();
    chk_msg("init_pre", 17'h04168, 1'b1);
    initialize = 1'b1; a_increase = 1'b1; a_old_root_in = '0; a_is_odd_cluster = 1'b0;
    step();
    initialize = 1'b0; a_increase = 1'b0;
    chk("init_growth_clr", 32'(is_fully_grown), 32'd0);
    chk_msg("init_inflight", 17'h04168, 1'b1);
    for (int s = 0; s < 3; s++) begin
      step();
      chk_msg("init_inflight_hold", 17'h04168, 1'b1);
    end
    tx_ready = 1'b1;
    step();
    chk("init_hs1", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    step();
    chk("init_load", 32'(tx_valid), 32'd0);
    step();
    chk_msg("init_msg", 17'h08000, 1'b1);
    tx_ready = 1'b1;
    step();
    chk("init_hs2", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      step();
      chk("init_quiet", 32'(tx_valid), 32'd0);
    end
    chk("init_grown", 32'(is_fully_grown), 32'd0);

    // Odd flag toggles and returns during one stall: no follow-up.
    a_old_root_in = 12'h011;
    step();
    step();
    chk_msg("odd_msg", 17'h00044, 1'b0);
    a_is_odd_cluster = 1'b1;
    step();
    chk_msg("odd_hold1", 17'h00044, 1'b0);
    a_is_odd_cluster = 1'b0;
    step();
    step();
    tx_ready = 1'b1;
    step();
    chk("odd_hs", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      step();
      chk("odd_quiet", 32'(tx_valid), 32'd0);
    end

    // Async reset during SEND drops tx_valid without a clock edge.
    a_old_root_in = 12'h022;
    step();
    step();
    chk_msg("rst_send", 17'h00088, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_data", 32'(tx_data), 32'd0);
    a_old_root_in = '0;
    step();
    reset = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      chk("rst_after", 32'(tx_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neighbor_link_tx.md
Name: neighbor_link_tx

Overview:
- Transmit end of a neighbor link whose edge crosses an FPGA boundary.
- Samples the local node's per-cycle link inputs (old root, increase pulse, odd-cluster flag) and coalesces changes into pending state.
- Emits compact update messages over a valid/ready channel to the remote FPGA, where a receiver rebuilds the b-side view of the edge.
- Tracks the edge's local growth so the node sees is_fully_grown without a round trip.

Parameters:
- LENGTH, 2, edge length in half-weights (>0); growth saturates here.
- ADDRESS_WIDTH, 12, width of a root address.
- COUNTER_WIDTH, $clog2(LENGTH+2), width of growth and increase-count fields (localparam).
- MSG_WIDTH, 3+ADDRESS_WIDTH+COUNTER_WIDTH, message width without parity (localparam): {opcode[1:0], odd, root, inc_count}.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- initialize  in  1  start of a new decoding round; same meaning as for the link.
- a_old_root_in  in  ADDRESS_WIDTH  local node's current root.
- a_increase  in  1  one-cycle growth pulse from the local node.
- a_is_odd_cluster  in  1  local cluster parity.
- is_fully_grown  out  1  local growth count >= LENGTH.
- tx_valid  out  1  message valid.
- tx_ready  in  1  remote channel accepts message.
- tx_data  out  MSG_WIDTH (+1 with parity)  message payload.

Behaviour:
- Reset (reset low, async): tx_valid=0, tx_data=0, growth=0, pending cleared, shadow root/odd=0, state IDLE.
- Opcodes: 00 UPDATE, 01 INIT, 10/11 reserved (never sent).
- Shadow regs hold the last root/odd captured into a message.
- Dirty when a_old_root_in != shadow root, a_is_odd_cluster != shadow odd, or pend_inc > 0.
- Growth: growth += a_increase while growth < LENGTH; pulses at or beyond LENGTH are ignored.
- pend_inc counts increases not yet sent. It increments only with growth, so total sent never exceeds LENGTH.
- is_fully_grown is combinational from the growth register.
- States:
  - IDLE: dirty or init_pend -> LOAD.
  - LOAD: register tx_data = INIT if init_pend, else UPDATE with the current root/odd and pend_inc. Update shadows, clear pend_inc (an increase in the same cycle becomes the new pend_inc=1), assert tx_valid -> SEND.
  - SEND: hold tx_data and tx_valid stable until tx_valid&&tx_ready. On handshake drop tx_valid -> IDLE.
- Latency:
  - A change sampled at edge t gives tx_valid high at t+2 (IDLE->LOAD->SEND).
  - Minimum message spacing is 3 cycles.
  - Back-to-back changes during SEND coalesce into one follow-up message.
- initialize (reset high):
  - Clears growth, pend_inc and shadows to 0, and sets init_pend.
  - Same-cycle a_increase is dropped (initialize wins).
  - In SEND, the in-flight message is not withdrawn. INIT follows after its handshake.
  - An INIT message carries zero root/odd/inc_count and clears init_pend on load.
- tx_ready high while tx_valid is low has no effect. tx_valid never depends combinationally on tx_ready.
- Reset mid-SEND: tx_valid drops immediately. The remote side must resynchronise on the next INIT.

Optional Feature:
- Macro NEIGHBOR_LINK_TX_PARITY_EN.
- Defined: tx_data is MSG_WIDTH+1 bits; the MSB is even parity over the lower MSG_WIDTH bits, computed at LOAD.
- Undefined: tx_data is exactly MSG_WIDTH bits; no parity logic.

Decomposition:
- Shared package helios_link_pkg holds:
  - opcode enum (OP_UPDATE, OP_INIT);
  - field offset/width functions of ADDRESS_WIDTH and COUNTER_WIDTH;
  - pack function.
- The matching receiver uses the same package.
- Tx state enum is local.
- No sub-module is needed; packing is a package function.

Test Plan:
- Reset low, then release; no inputs -> tx_valid stays 0 for 20 cycles; is_fully_grown=0.
- Root change to 0x05A with tx_ready=1 -> tx_valid at t+2, tx_data={00,0,0x05A,0}, one handshake, then idle.
- LENGTH=2, three a_increase pulses in consecutive cycles, tx_ready=0 for 10 cycles:
  - is_fully_grown=1 after the second pulse.
  - First message inc_count=1, held stable while stalled.
  - After ready, second message inc_count=1; the third pulse is never sent.
- initialize while SEND is stalled -> original message completes unchanged, then an INIT message {01,0,0,0}; same-cycle a_increase ignored (growth=0).
- Odd flag toggles 0->1->0 within one SEND stall -> no follow-up message (flag back at shadow value).
- With NEIGHBOR_LINK_TX_PARITY_EN, root 0x001, odd=1 -> tx_data MSB=0 (two ones); root 0x003, odd=1 -> MSB=1 (three ones).
